// File: rtl/idex_hazard_ctrl.sv
// Hazard/sequencing controller around ID_EX: load-use bubble, branch flush, memory-wait freeze with watchdog trap.
// Optional performance counters are enabled by defining HAZ_PERF_CNT_EN.
module idex_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT  = 255,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rt,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_flush,
    output logic             pipe_hold,
    output logic             mem_timeout,
    output logic [1:0]       state_o
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_ERR      = 2'd3
    } state_e;

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_VAL  = 8'(MEM_TIMEOUT);

    state_e     state_q, state_d;
    logic [2:0] fcnt_q, fcnt_d;
    logic [7:0] wcnt_q, wcnt_d;
    logic       timeout_q, timeout_d;
    logic       load_use;
    logic       load_stall;

    assign load_use = idex_memread && (idex_rt != 5'd0) &&
                      ((idex_rt == id_rs) || (id_uses_rt && (idex_rt == id_rt)));

    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        wcnt_d      = wcnt_q;
        timeout_d   = timeout_q;
        load_stall  = 1'b0;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_flush = 1'b0;
        pipe_hold   = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (branch_taken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    exmem_flush = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = ST_FLUSH;
                        fcnt_d  = FLUSH_RELOAD;
                    end
                end else if (dmem_req && !dmem_ready) begin
                    pipe_hold  = 1'b1;
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    state_d    = ST_MEM_WAIT;
                    wcnt_d     = 8'd1;
                end else if (load_use) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    load_stall  = 1'b1;
                end
            end
            ST_FLUSH: begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                if (branch_taken) begin
                    fcnt_d = FLUSH_RELOAD;
                end else if (fcnt_q <= 3'd1) begin
                    fcnt_d  = 3'd0;
                    state_d = ST_RUN;
                end else begin
                    fcnt_d = fcnt_q - 3'd1;
                end
            end
            ST_MEM_WAIT: begin
                // Counter already holds 1 for the cycle the stall was raised in RUN.
                if (dmem_ready) begin
                    state_d = ST_RUN;
                    wcnt_d  = 8'd0;
                end else begin
                    pipe_hold  = 1'b1;
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    if (wcnt_q == TIMEOUT_VAL) begin
                        timeout_d = 1'b1;
                        state_d   = ST_ERR;
                    end else begin
                        wcnt_d = wcnt_q + 8'd1;
                    end
                end
            end
            ST_ERR: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                pipe_hold   = 1'b1;
                idex_bubble = 1'b1;
            end
            default: state_d = ST_RUN;
        endcase

        if (!rst_n) begin
            state_d     = ST_RUN;
            fcnt_d      = 3'd0;
            wcnt_d      = 8'd0;
            timeout_d   = 1'b0;
            load_stall  = 1'b0;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
            pipe_hold   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        state_q   <= state_d;
        fcnt_q    <= fcnt_d;
        wcnt_q    <= wcnt_d;
        timeout_q <= timeout_d;
    end

    assign state_o     = state_q;
    assign mem_timeout = timeout_q;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] wait_cnt_q,  wait_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        if (!rst_n) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
            wait_cnt_d  = '0;
        end else begin
            if (load_stall && (stall_cnt_q != '1))
                stall_cnt_d = stall_cnt_q + 1'b1;
            if (ifid_flush && (flush_cnt_q != '1))
                flush_cnt_d = flush_cnt_q + 1'b1;
            if ((state_q == ST_MEM_WAIT) && (wait_cnt_q != '1))
                wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        stall_cnt_q <= stall_cnt_d;
        flush_cnt_q <= flush_cnt_d;
        wait_cnt_q  <= wait_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign wait_cnt  = wait_cnt_q;
`endif

endmodule

// File: tb/tb_idex_hazard_ctrl.sv
// Bench for idex_hazard_ctrl: directed sequences then random traffic, every cycle checked against a cycle-level model.
module tb_idex_hazard_ctrl;

    localparam int FC = 3;
    localparam int MT = 8;
    localparam int CW = 16;

    logic       clk = 1'b0;
    logic       rst_n, id_uses_rt, idex_memread, branch_taken, dmem_req, dmem_ready;
    logic [4:0] id_rs, id_rt, idex_rt;
    logic       pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush, pipe_hold, mem_timeout;
    logic [1:0] state_o;
`ifdef HAZ_PERF_CNT_EN
    logic [CW-1:0] stall_cnt, flush_cnt, wait_cnt;
`endif

    always #5 clk = ~clk;

    idex_hazard_ctrl #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .idex_memread(idex_memread), .idex_rt(idex_rt), .branch_taken(branch_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready), .pc_write(pc_write),
        .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .exmem_flush(exmem_flush), .pipe_hold(pipe_hold), .mem_timeout(mem_timeout),
        .state_o(state_o)
`ifdef HAZ_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: remaining flush-state cycles, current wait count (0 = not waiting), trap flag.
    bit m_valid = 1'b0;
    bit m_err;
    int m_flush_left, m_wait;
    int m_stall, m_flush, m_waitc;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input bit br, input bit req, input bit rdy, input bit mr,
                        input logic [4:0] xrt, input logic [4:0] rs, input logic [4:0] rt,
                        input bit urt);
        bit e_pc, e_ifw, e_iff, e_bub, e_exf, e_hold, hazard, stall_now;
        int e_state;
        int sat;
        sat = (1 << CW) - 1;
        rst_n = ~rst; branch_taken = br; dmem_req = req; dmem_ready = rdy;
        idex_memread = mr; idex_rt = xrt; id_rs = rs; id_rt = rt; id_uses_rt = urt;
        #1;
        hazard = mr && (xrt != 0) && (xrt == rs || (urt && xrt == rt));
        e_pc = 1; e_ifw = 1; e_iff = 0; e_bub = 0; e_exf = 0; e_hold = 0; stall_now = 0;
        e_state = m_err ? 3 : (m_wait > 0) ? 2 : (m_flush_left > 0) ? 1 : 0;

        if (rst) begin
            e_pc = 0; e_ifw = 0; e_iff = 1; e_bub = 1; e_exf = 1;
        end else if (m_err) begin
            e_pc = 0; e_ifw = 0; e_hold = 1; e_bub = 1;
        end else if (m_wait > 0) begin
            if (!rdy) begin
                e_pc = 0; e_ifw = 0; e_hold = 1;
            end
        end else if (m_flush_left > 0) begin
            e_iff = 1; e_bub = 1;
        end else if (br) begin
            e_iff = 1; e_bub = 1; e_exf = 1;
        end else if (req && !rdy) begin
            e_pc = 0; e_ifw = 0; e_hold = 1;
        end else if (hazard) begin
            e_pc = 0; e_ifw = 0; e_bub = 1; stall_now = 1;
        end

        check_val("pc_write", pc_write, e_pc);
        check_val("ifid_write", ifid_write, e_ifw);
        check_val("ifid_flush", ifid_flush, e_iff);
        check_val("idex_bubble", idex_bubble, e_bub);
        check_val("exmem_flush", exmem_flush, e_exf);
        check_val("pipe_hold", pipe_hold, e_hold);
        if (m_valid) begin
            check_val("state_o", state_o, e_state);
            check_val("mem_timeout", mem_timeout, m_err);
`ifdef HAZ_PERF_CNT_EN
            check_val("stall_cnt", stall_cnt, m_stall);
            check_val("flush_cnt", flush_cnt, m_flush);
            check_val("wait_cnt", wait_cnt, m_waitc);
`endif
        end

        if (rst) begin
            m_valid = 1; m_err = 0; m_flush_left = 0; m_wait = 0;
            m_stall = 0; m_flush = 0; m_waitc = 0;
        end else begin
            if (stall_now && m_stall < sat) m_stall++;
            if (e_iff && m_flush < sat) m_flush++;
            if (m_wait > 0 && !m_err && m_waitc < sat) m_waitc++;
            if (m_err) begin
                // trapped until reset
            end else if (m_wait > 0) begin
                if (rdy) m_wait = 0;
                else if (m_wait == MT) begin m_err = 1; m_wait = 0; end
                else m_wait++;
            end else if (m_flush_left > 0) begin
                if (br) m_flush_left = FC - 1;
                else m_flush_left--;
            end else if (br) begin
                m_flush_left = FC - 1;
            end else if (req && !rdy) begin
                m_wait = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    endtask

    initial begin
        @(posedge clk);
        #1;
        // reset held two cycles, then quiet
        step(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        step(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        idle(); idle();
        // load-use: single bubble, r0 exempt, rs=rt=dest still one bubble, rt ignored without id_uses_rt
        step(0, 0, 0, 0, 1, 5'd5, 5'd5, 5'd1, 0); idle();
        step(0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1); idle();
        step(0, 0, 0, 0, 1, 5'd7, 5'd7, 5'd7, 1); idle();
        step(0, 0, 0, 0, 1, 5'd9, 5'd2, 5'd9, 0);
        step(0, 0, 0, 0, 1, 5'd9, 5'd2, 5'd9, 1); idle();
        // branch flush for FC cycles
        step(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        repeat (4) idle();
        // memory wait of 4 cycles then release; ready without request ignored
        repeat (4) step(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        step(0, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0);
        step(0, 0, 0, 1, 1, 5'd3, 5'd3, 5'd0, 0);
        idle();
        // watchdog trap, held, then cleared by reset
        repeat (14) step(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        step(0, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
        step(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        idle();
        // branch and load-use together: branch wins
        step(0, 1, 0, 0, 1, 5'd4, 5'd4, 5'd4, 1);
        repeat (3) idle();
        // reset mid-flush and mid-wait
        step(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        step(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        step(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        step(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        step(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        idle();

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 1) == 0),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
